// File: rtl/beta_mem_decode_pkg.sv
// Shared definitions for the beta data-port decode: region codes (also used by the
// read-data mux), the ma[15:14] region mapping and the IO handshake state encoding.
package beta_mem_decode_pkg;

    localparam logic [2:0] REG_RAM = 3'd0;
    localparam logic [2:0] REG_IO  = 3'd1;
    localparam logic [2:0] REG_SHR = 3'd2;
    localparam logic [2:0] REG_SHW = 3'd3;
    localparam logic [2:0] REG_BAD = 3'd4;

    typedef enum logic [1:0] {
        IO_IDLE = 2'd0,
        IO_WAIT = 2'd1,
        IO_DONE = 2'd2
    } io_state_e;

    function automatic logic [2:0] region_of(input logic [1:0] sel);
        logic [2:0] r;
        r = REG_RAM;
        case (sel)
            2'b00: r = REG_RAM;
            2'b01: r = REG_IO;
            2'b10: r = REG_SHR;
            2'b11: r = REG_SHW;
            default: r = REG_RAM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/beta_mem_decode_io.sv
// IO handshake for the beta data port: three-state FSM, timeout counter and the
// registered io_* request signals.
module beta_io_handshake
    import beta_mem_decode_pkg::*;
#(
    parameter int IO_AW      = 8,
    parameter int IO_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             wr,
    input  logic [IO_AW-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic             io_ack,
    output logic             stall,
    output logic             timeout_evt,
    output logic             io_req,
    output logic             io_we,
    output logic [IO_AW-1:0] io_addr,
    output logic [31:0]      io_wdata
);

    localparam int              CNT_W    = $clog2(IO_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    io_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IO_IDLE;
        else          state <= state_nxt;
    end

    // An ack arriving on the timeout cycle still completes the access normally.
    always_comb begin
        state_nxt = state;
        case (state)
            IO_IDLE: if (start) state_nxt = IO_WAIT;
            IO_WAIT: if (io_ack || timed_out) state_nxt = IO_DONE;
            IO_DONE: state_nxt = IO_IDLE;
            default: state_nxt = IO_IDLE;
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IO_IDLE: stall = start;
            IO_WAIT: begin
                stall       = 1'b1;
                timeout_evt = timed_out && !io_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_req   <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
            cnt      <= '0;
        end else begin
            io_req <= (state_nxt == IO_WAIT);
            if (state == IO_IDLE && start) begin
                io_we    <= wr;
                io_addr  <= addr;
                io_wdata <= wdata;
                cnt      <= '0;
            end else if (state == IO_WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beta_mem_decode.sv
// Address decode and access control for the beta data port: region select, per-region
// enables, IO stall handshake and sticky/saturating error reporting.
module beta_mem_decode
    import beta_mem_decode_pkg::*;
#(
    parameter int RAM_AW     = 12,
    parameter int IO_AW      = 8,
    parameter int SH_AW      = 12,
    parameter int IO_TIMEOUT = 64,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          beta_ma,
    input  logic                 beta_moe,
    input  logic                 beta_wr,
    input  logic [31:0]          beta_mwd,
    output logic                 beta_stall,
    output logic [2:0]           read_select,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic                 ram_we,
    output logic [IO_AW-1:0]     io_addr,
    output logic [31:0]          io_wdata,
    output logic                 io_req,
    output logic                 io_we,
    input  logic                 io_ack,
    output logic [SH_AW-1:0]     sh_rd_addr,
    output logic [SH_AW-1:0]     sh_wr_addr,
    output logic                 sh_wr_we,
    output logic [31:0]          mem_wdata,
    output logic                 err_unmapped,
    output logic                 err_wprot,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clear
);

    logic       unmapped, access, io_start;
    logic [2:0] region;
    logic       ev_unmapped, ev_wprot, ev_timeout;
    logic [1:0] n_ev;
    logic       unused_ma;

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0] inc);
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
    endfunction

    assign unmapped    = |beta_ma[31:16];
    assign region      = unmapped ? REG_BAD : region_of(beta_ma[15:14]);
    assign access      = beta_moe | beta_wr;
    assign read_select = region;
    assign unused_ma   = ^beta_ma[1:0];

    // Upper in-region address bits are dropped, so each region aliases.
    assign ram_addr   = beta_ma[RAM_AW+1:2];
    assign sh_rd_addr = beta_ma[SH_AW+1:2];
    assign sh_wr_addr = beta_ma[SH_AW+1:2];
    assign mem_wdata  = beta_mwd;

    assign ram_we      = access & beta_wr & (region == REG_RAM);
    assign sh_wr_we    = access & beta_wr & (region == REG_SHW);
    assign io_start    = access & (region == REG_IO);
    assign ev_wprot    = access & beta_wr & (region == REG_SHR);
    assign ev_unmapped = access & unmapped;
    assign n_ev        = {1'b0, ev_unmapped} + {1'b0, ev_wprot} + {1'b0, ev_timeout};

    beta_io_handshake #(
        .IO_AW      (IO_AW),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) u_io (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (io_start),
        .wr          (beta_wr),
        .addr        (beta_ma[IO_AW+1:2]),
        .wdata       (beta_mwd),
        .io_ack      (io_ack),
        .stall       (beta_stall),
        .timeout_evt (ev_timeout),
        .io_req      (io_req),
        .io_we       (io_we),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata)
    );

    // Clear takes priority over any error arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_unmapped <= 1'b0;
            err_wprot    <= 1'b0;
            err_timeout  <= 1'b0;
            err_count    <= '0;
        end else if (err_clear) begin
            err_unmapped <= 1'b0;
            err_wprot    <= 1'b0;
            err_timeout  <= 1'b0;
            err_count    <= '0;
        end else begin
            err_unmapped <= err_unmapped | ev_unmapped;
            err_wprot    <= err_wprot | ev_wprot;
            err_timeout  <= err_timeout | ev_timeout;
            err_count    <= sat_add(err_count, n_ev);
        end
    end

endmodule

// File: tb/tb_beta_mem_decode.sv
// Scoreboard bench for beta_mem_decode: per-cycle expectations are queued as stimulus
// is applied and compared against the outputs at the following falling edge.
module tb_beta_mem_decode;
    import beta_mem_decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] beta_ma, beta_mwd;
    logic        beta_moe, beta_wr;
    logic        beta_stall;
    logic [2:0]  read_select;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic        io_req, io_we, io_ack;
    logic [11:0] sh_rd_addr, sh_wr_addr;
    logic        sh_wr_we;
    logic [31:0] mem_wdata;
    logic        err_unmapped, err_wprot, err_timeout;
    logic [7:0]  err_count;
    logic        err_clear;

    beta_mem_decode dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .beta_ma      (beta_ma),
        .beta_moe     (beta_moe),
        .beta_wr      (beta_wr),
        .beta_mwd     (beta_mwd),
        .beta_stall   (beta_stall),
        .read_select  (read_select),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_req       (io_req),
        .io_we        (io_we),
        .io_ack       (io_ack),
        .sh_rd_addr   (sh_rd_addr),
        .sh_wr_addr   (sh_wr_addr),
        .sh_wr_we     (sh_wr_we),
        .mem_wdata    (mem_wdata),
        .err_unmapped (err_unmapped),
        .err_wprot    (err_wprot),
        .err_timeout  (err_timeout),
        .err_count    (err_count),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rsel;
        logic        stall;
        logic        ram_we;
        logic [11:0] ram_addr;
        logic        sh_we;
        logic [11:0] sh_addr;
        logic        io_req;
        logic [7:0]  io_addr;
        logic        io_we;
        logic [2:0]  errs;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    string       phase = "reset";
    logic [7:0]  m_io_addr;
    logic        m_io_we;
    logic [2:0]  m_errs;
    logic [7:0]  m_ecnt;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, obs, expv);
    endtask

    task automatic drive(input logic [31:0] ma, input logic moe, input logic wr,
                         input logic [31:0] wd);
        beta_ma  = ma;
        beta_moe = moe;
        beta_wr  = wr;
        beta_mwd = wd;
    endtask

    // Queue this cycle's expectation, then compare at the falling edge and advance.
    task automatic step(input logic [2:0] rsel, input logic stall, input logic rwe,
                        input logic swe, input logic req);
        exp_t e;
        exp_t got;
        e.rsel = rsel;  e.stall = stall;  e.ram_we = rwe;  e.sh_we = swe;  e.io_req = req;
        e.ram_addr = beta_ma[13:2];
        e.sh_addr  = beta_ma[13:2];
        e.io_addr = m_io_addr;  e.io_we = m_io_we;  e.errs = m_errs;  e.ecnt = m_ecnt;
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        chk_val("read_select", 32'(read_select), 32'(got.rsel));
        chk_val("beta_stall",  32'(beta_stall),  32'(got.stall));
        chk_val("ram_we",      32'(ram_we),      32'(got.ram_we));
        chk_val("ram_addr",    32'(ram_addr),    32'(got.ram_addr));
        chk_val("sh_wr_we",    32'(sh_wr_we),    32'(got.sh_we));
        chk_val("sh_wr_addr",  32'(sh_wr_addr),  32'(got.sh_addr));
        chk_val("sh_rd_addr",  32'(sh_rd_addr),  32'(got.sh_addr));
        chk_val("io_req",      32'(io_req),      32'(got.io_req));
        chk_val("io_addr",     32'(io_addr),     32'(got.io_addr));
        chk_val("io_we",       32'(io_we),       32'(got.io_we));
        chk_val("err_flags",   32'({err_unmapped, err_wprot, err_timeout}), 32'(got.errs));
        chk_val("err_count",   32'(err_count),   32'(got.ecnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;  io_ack = 1'b0;  err_clear = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        m_io_addr = '0;  m_io_we = 1'b0;  m_errs = '0;  m_ecnt = '0;

        phase = "reset";
        step(REG_RAM, 0, 0, 0, 0);
        chk_val("io_wdata", io_wdata, 32'h0);
        reset_n = 1'b1;

        phase = "ram_rd";
        drive(32'h0000_0010, 1, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);
        chk_val("ram_addr_4", 32'(ram_addr), 32'd4);
        phase = "ram_wr";
        drive(32'h0000_0020, 0, 1, 32'h55);
        step(REG_RAM, 0, 1, 0, 0);

        phase = "shw_wr";
        drive(32'h0000_C008, 0, 1, 32'hDEAD_BEEF);
        step(REG_SHW, 0, 0, 1, 0);
        chk_val("mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk_val("sh_wr_addr_2", 32'(sh_wr_addr), 32'd2);
        phase = "shw_both";
        drive(32'h0000_C00C, 1, 1, 32'h1);
        step(REG_SHW, 0, 0, 1, 0);
        phase = "shr_rd";
        drive(32'h0000_8004, 1, 0, 32'h0);
        step(REG_SHR, 0, 0, 0, 0);

        phase = "io_rd";
        drive(32'h0000_4004, 1, 0, 32'h0);
        step(REG_IO, 1, 0, 0, 0);
        m_io_addr = 8'd1;  m_io_we = 1'b0;
        step(REG_IO, 1, 0, 0, 1);
        step(REG_IO, 1, 0, 0, 1);
        io_ack = 1'b1;
        step(REG_IO, 1, 0, 0, 1);
        io_ack = 1'b0;
        step(REG_IO, 0, 0, 0, 0);
        phase = "ack_idle";
        drive(32'h0, 0, 0, 32'h0);
        io_ack = 1'b1;
        step(REG_RAM, 0, 0, 0, 0);
        io_ack = 1'b0;
        step(REG_RAM, 0, 0, 0, 0);

        phase = "io_timeout";
        drive(32'h0000_4010, 0, 1, 32'h1234_5678);
        step(REG_IO, 1, 0, 0, 0);
        m_io_addr = 8'd4;  m_io_we = 1'b1;
        for (int i = 0; i < 64; i++) step(REG_IO, 1, 0, 0, 1);
        chk_val("io_wdata", io_wdata, 32'h1234_5678);
        m_errs = 3'b001;  m_ecnt = 8'd1;
        step(REG_IO, 0, 0, 0, 0);
        drive(32'h0, 0, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);

        phase = "clear1";
        err_clear = 1'b1;
        step(REG_RAM, 0, 0, 0, 0);
        err_clear = 1'b0;  m_errs = '0;  m_ecnt = '0;
        step(REG_RAM, 0, 0, 0, 0);

        phase = "wprot";
        drive(32'h0000_8000, 0, 1, 32'hAA);
        step(REG_SHR, 0, 0, 0, 0);
        m_errs = 3'b010;  m_ecnt = 8'd1;
        phase = "unmapped";
        drive(32'h0001_0000, 0, 1, 32'hBB);
        step(REG_BAD, 0, 0, 0, 0);
        m_errs = 3'b110;  m_ecnt = 8'd2;
        drive(32'h0, 0, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);
        phase = "clear2";
        err_clear = 1'b1;
        step(REG_RAM, 0, 0, 0, 0);
        err_clear = 1'b0;  m_errs = '0;  m_ecnt = '0;
        step(REG_RAM, 0, 0, 0, 0);

        phase = "clear_wins";
        drive(32'h0001_0000, 1, 0, 32'h0);
        err_clear = 1'b1;
        step(REG_BAD, 0, 0, 0, 0);
        err_clear = 1'b0;
        drive(32'h0, 0, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);

        phase = "saturate";
        drive(32'h0002_0000, 1, 0, 32'h0);
        for (int i = 0; i < 260; i++) begin
            step(REG_BAD, 0, 0, 0, 0);
            m_errs = 3'b100;
            if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
        end
        drive(32'h0, 0, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);
        err_clear = 1'b1;
        step(REG_RAM, 0, 0, 0, 0);
        err_clear = 1'b0;  m_errs = '0;  m_ecnt = '0;
        step(REG_RAM, 0, 0, 0, 0);

        phase = "rst_io";
        drive(32'h0000_4000, 1, 0, 32'h0);
        step(REG_IO, 1, 0, 0, 0);
        m_io_addr = 8'd0;  m_io_we = 1'b0;
        step(REG_IO, 1, 0, 0, 1);
        step(REG_IO, 1, 0, 0, 1);
        reset_n = 1'b0;
        step(REG_IO, 1, 0, 0, 0);
        reset_n = 1'b1;
        step(REG_IO, 1, 0, 0, 0);
        step(REG_IO, 1, 0, 0, 1);
        io_ack = 1'b1;
        step(REG_IO, 1, 0, 0, 1);
        io_ack = 1'b0;
        step(REG_IO, 0, 0, 0, 0);
        drive(32'h0, 0, 0, 32'h0);
        step(REG_RAM, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/beta_mem_decode.md
Name: beta_mem_decode

Overview:
- Address-decode and access-control stage for the beta CPU data port; sits directly upstream of the beta read-data mux.
- Maps each beta load/store to one of four regions (RAM, IO, shared_read frame buffer, shared_write frame buffer).
- Drives per-region address and enables, and produces the 3-bit read_select that the mux registers one cycle later.
- Stalls the beta during IO handshakes; flags unmapped, illegal and timed-out accesses.

Parameters:
- RAM_AW, 12, RAM word-address width.
- IO_AW, 8, IO word-address width.
- SH_AW, 12, word-address width of each shared buffer.
- IO_TIMEOUT, 64, max IO_WAIT cycles before an IO access is forced complete (≥2).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- beta_ma  in  32  beta byte address.
- beta_moe  in  1  beta read request.
- beta_wr  in  1  beta write request.
- beta_mwd  in  32  beta write data.
- beta_stall  out  1  hold beta (combinational).
- read_select  out  3  region code to the read mux (combinational).
- ram_addr  out  RAM_AW  ram word address.
- ram_we  out  1  ram write enable.
- io_addr  out  IO_AW  IO word address (registered).
- io_wdata  out  32  IO write data (registered).
- io_req  out  1  IO request (registered).
- io_we  out  1  IO write qualifier, valid with io_req.
- io_ack  in  1  IO completion, single-cycle pulse.
- sh_rd_addr  out  SH_AW  shared_read buffer word address.
- sh_wr_addr  out  SH_AW  shared_write buffer word address.
- sh_wr_we  out  1  shared_write buffer write enable.
- mem_wdata  out  32  write data to ram and shared_write (= beta_mwd).
- err_unmapped  out  1  sticky: unmapped access seen.
- err_wprot  out  1  sticky: write to shared_read seen.
- err_timeout  out  1  sticky: IO timeout seen.
- err_count  out  ERR_CNT_W  saturating count of all errors.
- err_clear  in  1  sync clear of the sticky flags and err_count.

Behaviour:
- Region decode:
  - beta_ma[31:16]≠0 → unmapped.
  - Otherwise beta_ma[15:14]: 00 RAM (read_select=0), 01 IO (1), 10 shared_read (2), 11 shared_write (3).
  - Unmapped → read_select=4; the mux treats 4 as its default.
- Word addresses: ram_addr=beta_ma[RAM_AW+1:2], sh_*_addr=beta_ma[SH_AW+1:2], io_addr latched from beta_ma[IO_AW+1:2]. Upper bits inside a region are ignored (alias).
- access = beta_moe | beta_wr. If both are set, the access is treated as a write.
- read_select is combinational from beta_ma every cycle, including while stalled.
- ram_we = access & wr & RAM region & !unmapped.
- sh_wr_we = access & wr & shared_write region.
- Write to shared_read: no enable asserted; err_wprot set; counted.
- Unmapped access: no enables; err_unmapped set; counted once per access cycle.
- IO FSM, states IDLE, IO_WAIT, IO_DONE:
  - IDLE: on access to the IO region, beta_stall=1 combinationally in that cycle. Next edge: io_req←1, io_we←wr, io_addr/io_wdata latched, cnt←0, go to IO_WAIT.
  - IO_WAIT: beta_stall=1, io_req held; cnt increments each cycle.
    - io_ack → io_req←0, go to IO_DONE.
    - cnt==IO_TIMEOUT-1 without ack → io_req←0, err_timeout set, counted, go to IO_DONE.
    - ack and timeout in the same cycle → ack wins; no error.
  - IO_DONE: beta_stall=0, so the beta completes the access. IO-region decode is suppressed in this cycle; the mux samples read_select=1. Always returns to IDLE next cycle.
  - io_ack outside IO_WAIT is ignored.
- Back-to-back IO accesses: each costs a minimum of 3 cycles (IDLE, WAIT, DONE).
- RAM and shared accesses never stall.
- err_count saturates at all-ones.
- Error event coincident with err_clear: clear wins, event is lost.
- Reset values: state IDLE, io_req 0, io_we 0, io_addr 0, io_wdata 0, cnt 0, sticky flags 0, err_count 0.
- Reset mid-IO-access: io_req drops immediately; beta_stall follows the decode (asserts again if the beta still presents the IO access).

Decomposition:
- Shared package holds:
  - region codes REG_RAM=0, REG_IO=1, REG_SHR=2, REG_SHW=3, REG_BAD=4;
  - the ma[15:14] region mapping;
  - IO FSM state encodings.
- The read mux uses the same region codes.
- One sub-module: beta_io_handshake (FSM, timeout counter, io_* registers). The decode stays in the top level.

Test Plan:
- Read ma=0x0000_0010, moe=1 → read_select=0, ram_addr=4, ram_we=0, no stall, no errors.
- Write ma=0x0000_C008, wr=1, mwd=0xDEADBEEF → sh_wr_we=1, sh_wr_addr=2, mem_wdata=0xDEADBEEF, read_select=3.
- IO read ma=0x4004; io_ack three cycles after io_req rises → stall 4 cycles, io_addr=1, io_we=0, IO_DONE one cycle, read_select=1 throughout, no error.
- IO write with io_ack never asserted, IO_TIMEOUT=64 → io_req high exactly 64 cycles, err_timeout=1, err_count=1, then IO_DONE.
- Write 0x8000, then access 0x0001_0000 → err_wprot=1, err_unmapped=1, err_count=2, no enables, read_select=4. Pulse err_clear → all cleared.
- Assert reset_n low during IO_WAIT → io_req=0, state IDLE.
